// File: rtl/join_input_fifo_if.sv
// Handshake bundle for one join_input_fifo: upstream push side, downstream pop side, occupancy status.
// slave = the FIFO itself; master = whatever drives and consumes it.
interface join_input_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, count, full, empty
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, count, full, empty
    );
endinterface

// File: rtl/join_input_fifo.sv
// Elastic DEPTH-entry FIFO feeding one operand of the two-input join; any DEPTH >= 2.
// Optional JOIN_INPUT_FIFO_FALLTHROUGH_EN: zero-latency bypass when empty.
module join_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    join_input_fifo_if.slave  bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;

    logic full, empty, in_ready, push, pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    // A pop this cycle frees the slot, so a full FIFO can still accept.
    assign in_ready = !full || bus.data_out_ready;

`ifdef JOIN_INPUT_FIFO_FALLTHROUGH_EN
    logic bypass;
    assign bypass = empty && bus.data_in_valid && bus.data_out_ready;
    assign push   = bus.data_in_valid && in_ready && !bypass;
    assign pop    = !empty && bus.data_out_ready;

    assign bus.data_out_valid = !empty || bus.data_in_valid;
    always_comb begin
        bus.data_out = '0;
        if (!empty)
            bus.data_out = mem[rd_ptr];
        else if (bus.data_in_valid)
            bus.data_out = bus.data_in;
    end
`else
    assign push = bus.data_in_valid && in_ready;
    assign pop  = !empty && bus.data_out_ready;

    assign bus.data_out_valid = !empty;
    assign bus.data_out       = empty ? '0 : mem[rd_ptr];
`endif

    assign bus.data_in_ready = in_ready;
    assign bus.count         = cnt;
    assign bus.full          = full;
    assign bus.empty         = empty;

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
